// File: rtl/seg7_scan_driver.sv
// ============================================================================
// Module   : seg7_scan_driver
// Purpose  : Scans four BCD digits onto a shared active-low 7-segment bus with
//            per-digit decimal points, leading-zero blanking and dead time.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg7_scan_driver #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int REFRESH_HZ   = 250,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_en,
  input  logic        blank_lz,
  output logic [6:0]  segmentos,
  output logic        dp,
  output logic [3:0]  displays,
  output logic        frame_tick
);

  localparam int SLOT = CLK_HZ / (4 * REFRESH_HZ);
  localparam int PW   = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam logic [PW-1:0] c_SLOT_LAST = PW'(SLOT - 1);
  localparam logic [PW-1:0] c_BLANK     = PW'(BLANK_CYCLES);
  localparam logic [6:0]    c_SEG_OFF   = 7'h7F;

  generate
    if (!(SLOT > BLANK_CYCLES && BLANK_CYCLES >= 1)) begin : g_param_check
      $error("seg7_scan_driver: requires SLOT > BLANK_CYCLES >= 1");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_run;
  logic [PW-1:0] r_pre;
  logic [PW-1:0] w_pre_nxt;
  logic [1:0]    r_idx;
  logic [1:0]    w_idx_nxt;
  logic          w_frame_start;

  logic [15:0]   r_sh_dig;
  logic [3:0]    r_sh_dp;
  logic          r_sh_lz;
  logic [15:0]   w_sh_dig;
  logic [3:0]    w_sh_dp;
  logic          w_sh_lz;

  logic [3:0]    w_digit;
  logic [3:0]    w_lz_mask;
  logic [6:0]    w_seg_nxt;
  logic          w_dp_nxt;
  logic [3:0]    w_disp_nxt;
  logic          w_tick_nxt;

  function automatic logic [6:0] f_decode(input logic [3:0] d);
    case (d)
      4'd0:    f_decode = 7'b0000001;
      4'd1:    f_decode = 7'b1001111;
      4'd2:    f_decode = 7'b0010010;
      4'd3:    f_decode = 7'b0000110;
      4'd4:    f_decode = 7'b1001100;
      4'd5:    f_decode = 7'b0100100;
      4'd6:    f_decode = 7'b0100000;
      4'd7:    f_decode = 7'b0001111;
      4'd8:    f_decode = 7'b0000000;
      4'd9:    f_decode = 7'b0000100;
      default: f_decode = c_SEG_OFF;
    endcase
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_BLANK;
      r_run      <= 1'b0;
      r_pre      <= '0;
      r_idx      <= 2'd0;
      r_sh_dig   <= 16'h0000;
      r_sh_dp    <= 4'h0;
      r_sh_lz    <= 1'b0;
      segmentos  <= c_SEG_OFF;
      dp         <= 1'b1;
      displays   <= 4'hF;
      frame_tick <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_run      <= enable;
      r_pre      <= w_pre_nxt;
      r_idx      <= w_idx_nxt;
      r_sh_dig   <= w_sh_dig;
      r_sh_dp    <= w_sh_dp;
      r_sh_lz    <= w_sh_lz;
      segmentos  <= w_seg_nxt;
      dp         <= w_dp_nxt;
      displays   <= w_disp_nxt;
      frame_tick <= w_tick_nxt;
    end
  end

  // Outputs are computed for the scan position being entered, so the
  // registered outputs always line up with the registered counters.
  always_comb begin
    w_pre_nxt     = '0;
    w_idx_nxt     = 2'd0;
    w_frame_start = 1'b0;
    w_state_nxt   = ST_BLANK;
    w_seg_nxt     = c_SEG_OFF;
    w_dp_nxt      = 1'b1;
    w_disp_nxt    = 4'hF;
    w_tick_nxt    = 1'b0;

    if (enable) begin
      if (!r_run) begin
        w_frame_start = 1'b1;
      end else if (r_pre == c_SLOT_LAST) begin
        w_idx_nxt     = r_idx + 2'd1;
        w_frame_start = (r_idx == 2'd3);
      end else begin
        w_pre_nxt = r_pre + {{(PW-1){1'b0}}, 1'b1};
        w_idx_nxt = r_idx;
      end
    end

    w_sh_dig = w_frame_start ? digits   : r_sh_dig;
    w_sh_dp  = w_frame_start ? dp_en    : r_sh_dp;
    w_sh_lz  = w_frame_start ? blank_lz : r_sh_lz;

    // A digit is a leading zero when it and every digit to its left are zero.
    w_lz_mask[3] = (w_sh_dig[15:12] == 4'd0);
    w_lz_mask[2] = w_lz_mask[3] && (w_sh_dig[11:8] == 4'd0);
    w_lz_mask[1] = w_lz_mask[2] && (w_sh_dig[7:4] == 4'd0);
    w_lz_mask[0] = 1'b0;

    w_digit = w_sh_dig[{w_idx_nxt, 2'b00} +: 4];

    if (w_pre_nxt >= c_BLANK) begin
      w_state_nxt = ST_SHOW;
    end

    if (enable) begin
      w_tick_nxt = w_frame_start;
      if (w_state_nxt == ST_SHOW) begin
        w_disp_nxt = ~(4'b0001 << w_idx_nxt);
        w_dp_nxt   = ~w_sh_dp[w_idx_nxt];
        w_seg_nxt  = (w_sh_lz && w_lz_mask[w_idx_nxt]) ? c_SEG_OFF : f_decode(w_digit);
      end
    end
  end

endmodule

`default_nettype wire
